// File: rtl/twos_negate_pkg.sv
// Shared types and defaults for the serial two's-complement negation block.
package twos_negate_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} neg_state_t;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CHUNK_DEF = 8;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/inc_chunk.sv
// One slice of the serial incrementer: adds a single carry bit into a CHUNK-bit slice.
module inc_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_slice,
  input  logic             i_carry,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_carry
);

  always_comb begin
    {o_carry, o_sum} = {1'b0, i_slice} + (CHUNK + 1)'(i_carry);
  end

endmodule

// File: rtl/twos_negate_serial_32bit.sv
// Turns a one's-complement operand c = ~a into -a = c + 1, rippling the +1 carry one
// CHUNK-bit slice per cycle, with overflow and zero flags and valid/ready on both sides.
module twos_negate_serial_32bit
  import twos_negate_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_neg,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] OVF_PAT  = {1'b0, {(WIDTH - 1){1'b1}}};

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("twos_negate_serial_32bit: WIDTH must be a multiple of CHUNK");
  end

  neg_state_t       r_state;
  neg_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_last;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_neg;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;

  assign w_slice = r_work[r_idx * CHUNK +: CHUNK];

  inc_chunk #(
    .CHUNK (CHUNK)
  ) u_inc_chunk (
    .i_slice (w_slice),
    .i_carry (r_carry),
    .o_sum   (w_sum),
    .o_carry (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = CALC;
      CALC:    if (r_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_neg   = r_neg;
    out_ovf   = r_ovf;
    out_zero  = r_zero;
  end

  // All slices are always visited (fixed latency); r_last marks the extra cycle in which
  // the finished word and flags are captured into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work     <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_last     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_neg      <= '0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work     <= in_c;
            r_carry    <= 1'b1;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_ovf_pend <= (in_c == OVF_PAT);
          end
        end
        CALC: begin
          if (!r_last) begin
            r_work[r_idx * CHUNK +: CHUNK] <= w_sum;
            r_carry                        <= w_cout;
            if (r_idx == LAST_IDX) begin
              r_last <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_neg  <= r_work;
            r_ovf  <= r_ovf_pend;
            r_zero <= (r_work == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_negate_serial_32bit.sv
// Self-checking bench: directed corner cases plus randomized traffic scored against c + 1.
module tb_twos_negate_serial_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_neg;
  logic        out_ovf;
  logic        out_zero;

  int n_checks;
  int n_errors;

  twos_negate_serial_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: -a = c + 1 modulo 2^32; a = 0x8000_0000 (c = 0x7FFF_FFFF) is not representable.
  function automatic logic [31:0] ref_neg(input logic [31:0] c);
    return c + 32'd1;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] c);
    return (c == 32'h7FFF_FFFF);
  endfunction

  function automatic logic ref_zero(input logic [31:0] c);
    return (ref_neg(c) == 32'd0);
  endfunction

  task automatic run_op(input logic [31:0] c, input int stall);
    int          lat;
    bit          seen;
    logic [31:0] held;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    in_c      = c;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_c     = ~c;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1;
    end
    check("latency", 32'(lat), 32'd5);
    check("neg", out_neg, ref_neg(c));
    check("ovf", 32'(out_ovf), 32'(ref_ovf(c)));
    check("zero", 32'(out_zero), 32'(ref_zero(c)));
    check("busy_ready", 32'(in_ready), 32'd0);
    held = out_neg;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_neg", out_neg, held);
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  localparam int NOPS = 200;

  initial begin
    logic [31:0] q[$];
    logic [31:0] c;
    int          sent;
    int          got;
    int          r;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_c      = '0;
    out_ready = 1'b1;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_neg", out_neg, 32'd0);
    check("rst_flags", {30'd0, out_ovf, out_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'hFFFF_FFFE, 0);
    run_op(32'hFFFF_FFFF, 0);
    run_op(32'h7FFF_FFFF, 0);
    run_op(32'h1234_56FF, 10);

    // Abort in the second CALC cycle.
    @(negedge clk);
    in_c     = 32'h0000_00FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_neg", out_neg, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_out", 32'(out_valid), 32'd0);
    run_op(32'hFFFF_FF00, 0);

    // Randomized traffic with stalls on both sides.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20000 && (sent < NOPS || q.size() > 0); cyc++) begin
      @(negedge clk);
      in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 9);
      in_c      = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h7FFF_FFFF : $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(in_c);
        sent++;
      end
      if (out_valid && out_ready) begin
        check("rnd_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          c = q.pop_front();
          check("rnd_neg", out_neg, ref_neg(c));
          check("rnd_ovf", 32'(out_ovf), 32'(ref_ovf(c)));
          check("rnd_zero", 32'(out_zero), 32'(ref_zero(c)));
          got++;
        end
      end
    end
    check("rnd_sent", 32'(sent), 32'(NOPS));
    check("rnd_got", 32'(got), 32'(sent));
    check("rnd_drained", 32'(q.size()), 32'd0);

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_extra_out", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
